execute_m: RTL and testbench

EXECUTE_M -- requirements
Module: execute_m

---
 rtl/execute_m.sv | 260 ++++++++++++++++++++++++++
 tb/tb_execute_m.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_m.sv
// Execute stage: single-cycle ALU with operand forwarding, plus a multi-cycle
// multiplier and restoring divider sequenced by an IDLE/MUL/DIV state machine.
package execute_pkg;
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_ADDI, ALU_LUI,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_ctrl_e;
endpackage

module execute_m
    import execute_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_LAT  = 2,
    parameter int DIV_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    input  alu_ctrl_e       op_i,
    input  logic [1:0]      forwardA_i,
    input  logic [1:0]      forwardB_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] forwM_data_i,
    input  logic [XLEN-1:0] forwW_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wr_ena_o
);
    localparam int DIV_CYC = XLEN / DIV_BITS;
    localparam int CW      = $clog2(DIV_CYC);
    localparam int SHW     = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e            r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_opa;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_rem;
    logic [4:0]        r_rd;
    logic              r_mul_hi;
    logic              r_a_sx;
    logic              r_b_sx;
    logic              r_is_rem;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_valid;
    logic [XLEN-1:0]   r_rd_data;
    logic [4:0]        r_rd_addr;
    logic              r_wr_ena;

    logic [XLEN-1:0]   w_op_a;
    logic [XLEN-1:0]   w_op_b;
    logic [XLEN-1:0]   w_alu_res;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN-1:0]   w_min_neg;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_is_rem_op;
    logic              w_div_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_div_special;
    logic              w_mc_op;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_div_res;

    always_comb begin
        w_op_a = rs1_data_i;
        w_op_b = rs2_data_i;
        case (forwardA_i)
            2'b01:   w_op_a = forwW_data_i;
            2'b10:   w_op_a = forwM_data_i;
            default: w_op_a = rs1_data_i;
        endcase
        case (forwardB_i)
            2'b01:   w_op_b = forwW_data_i;
            2'b10:   w_op_b = forwM_data_i;
            default: w_op_b = rs2_data_i;
        endcase
    end

    always_comb begin
        w_alu_res = '0;
        case (op_i)
            ALU_ADD:  w_alu_res = w_op_a + w_op_b;
            ALU_SUB:  w_alu_res = w_op_a - w_op_b;
            ALU_SLL:  w_alu_res = w_op_a << w_op_b[SHW-1:0];
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
            ALU_SRL:  w_alu_res = w_op_a >> w_op_b[SHW-1:0];
            ALU_SRA:  w_alu_res = $unsigned($signed(w_op_a) >>> w_op_b[SHW-1:0]);
            ALU_OR:   w_alu_res = w_op_a | w_op_b;
            ALU_AND:  w_alu_res = w_op_a & w_op_b;
            ALU_ADDI: w_alu_res = w_op_a + imm_i;
            ALU_LUI:  w_alu_res = imm_i;
            default:  w_alu_res = '0;
        endcase
    end

    assign w_is_mul      = op_i inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    assign w_is_div      = op_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign w_is_rem_op   = (op_i == ALU_REM) | (op_i == ALU_REMU);
    assign w_div_signed  = (op_i == ALU_DIV) | (op_i == ALU_REM);
    assign w_a_neg       = w_div_signed & w_op_a[XLEN-1];
    assign w_b_neg       = w_div_signed & w_op_b[XLEN-1];
    assign w_min_neg     = {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero    = (w_op_b == '0);
    assign w_div_ovf     = w_div_signed & (w_op_a == w_min_neg) & (&w_op_b);
    assign w_div_special = w_is_div & (w_div_zero | w_div_ovf);
    assign w_mc_op       = w_is_mul | (w_is_div & ~w_div_special);

    // Zero divisor and signed overflow finish in one cycle with fixed results
    always_comb begin
        if (w_div_zero) w_special_res = w_is_rem_op ? w_op_a : '1;
        else            w_special_res = w_is_rem_op ? '0 : w_op_a;
    end

    assign w_mul_a   = {{XLEN{r_a_sx & r_opa[XLEN-1]}}, r_opa};
    assign w_mul_b   = {{XLEN{r_b_sx & r_opb[XLEN-1]}}, r_opb};
    assign w_prod    = w_mul_a * w_mul_b;
    assign w_mul_res = r_mul_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

    // r_opa doubles as the dividend/quotient shift register during a divide
    logic [XLEN-1:0] w_rem_s [DIV_BITS+1];
    logic [XLEN-1:0] w_quo_s [DIV_BITS+1];
    assign w_rem_s[0] = r_rem;
    assign w_quo_s[0] = r_opa;

    generate
        for (genvar gi = 0; gi < DIV_BITS; gi++) begin : g_div_step
            logic [XLEN:0] w_sh;
            logic [XLEN:0] w_diff;
            logic          w_ge;
            assign w_sh           = {w_rem_s[gi], w_quo_s[gi][XLEN-1]};
            assign w_diff         = w_sh - {1'b0, r_opb};
            assign w_ge           = ~w_diff[XLEN];
            assign w_rem_s[gi+1]  = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
            assign w_quo_s[gi+1]  = {w_quo_s[gi][XLEN-2:0], w_ge};
        end
    endgenerate

    assign w_quo_fix = r_neg_q ? -w_quo_s[DIV_BITS] : w_quo_s[DIV_BITS];
    assign w_rem_fix = r_neg_r ? -w_rem_s[DIV_BITS] : w_rem_s[DIV_BITS];
    assign w_div_res = r_is_rem ? w_rem_fix : w_quo_fix;

    assign stall_o = rstn_i & ~flush_i &
                     (((r_state == S_IDLE) & valid_i & w_mc_op) |
                      ((r_state != S_IDLE) & (r_cnt != '0)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_rem     <= '0;
            r_rd      <= '0;
            r_mul_hi  <= 1'b0;
            r_a_sx    <= 1'b0;
            r_b_sx    <= 1'b0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_valid   <= 1'b0;
            r_rd_data <= '0;
            r_rd_addr <= '0;
            r_wr_ena  <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_rd_data <= '0;
            r_rd_addr <= '0;
            r_wr_ena  <= 1'b0;
            if (flush_i) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (valid_i) begin
                            if (w_is_mul) begin
                                r_state  <= S_MUL;
                                r_cnt    <= CW'(MUL_LAT - 1);
                                r_opa    <= w_op_a;
                                r_opb    <= w_op_b;
                                r_rd     <= rd_addr_i;
                                r_mul_hi <= (op_i != ALU_MUL);
                                r_a_sx   <= (op_i == ALU_MULH) | (op_i == ALU_MULHSU);
                                r_b_sx   <= (op_i == ALU_MULH);
                            end else if (w_is_div && !w_div_special) begin
                                r_state  <= S_DIV;
                                r_cnt    <= CW'(DIV_CYC - 1);
                                r_opa    <= w_a_neg ? -w_op_a : w_op_a;
                                r_opb    <= w_b_neg ? -w_op_b : w_op_b;
                                r_rem    <= '0;
                                r_rd     <= rd_addr_i;
                                r_is_rem <= w_is_rem_op;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                            end else begin
                                r_valid   <= 1'b1;
                                r_rd_data <= w_is_div ? w_special_res : w_alu_res;
                                r_rd_addr <= rd_addr_i;
                                r_wr_ena  <= (rd_addr_i != 5'd0);
                            end
                        end
                    end
                    S_MUL: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_state   <= S_IDLE;
                            r_valid   <= 1'b1;
                            r_rd_data <= w_mul_res;
                            r_rd_addr <= r_rd;
                            r_wr_ena  <= (r_rd != 5'd0);
                        end
                    end
                    S_DIV: begin
                        r_opa <= w_quo_s[DIV_BITS];
                        r_rem <= w_rem_s[DIV_BITS];
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_state   <= S_IDLE;
                            r_valid   <= 1'b1;
                            r_rd_data <= w_div_res;
                            r_rd_addr <= r_rd;
                            r_wr_ena  <= (r_rd != 5'd0);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign valid_o     = r_valid;
    assign rd_data_o   = r_rd_data;
    assign rd_addr_o   = r_rd_addr;
    assign rd_wr_ena_o = r_wr_ena;

endmodule

// File: tb/tb_execute_m.sv
// Directed self-checking bench for execute_m: ALU/forwarding, multiply and
// divide latency, special divide cases, flush and asynchronous reset.
module tb_execute_m;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    alu_ctrl_e   op = ALU_ADD;
    logic [1:0]  fa = 2'b00;
    logic [1:0]  fb = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [31:0] fm = '0;
    logic [31:0] fw = '0;
    logic [31:0] imm = '0;
    logic [4:0]  rd = '0;
    logic        stall;
    logic        vo;
    logic [31:0] rdat;
    logic [4:0]  raddr;
    logic        wr;

    int n_cmp = 0;
    int n_err = 0;

    execute_m #(.XLEN(32), .MUL_LAT(2), .DIV_BITS(1)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .valid_i      (valid),
        .op_i         (op),
        .forwardA_i   (fa),
        .forwardB_i   (fb),
        .rs1_data_i   (rs1),
        .rs2_data_i   (rs2),
        .forwM_data_i (fm),
        .forwW_data_i (fw),
        .imm_i        (imm),
        .rd_addr_i    (rd),
        .flush_i      (flush),
        .stall_o      (stall),
        .valid_o      (vo),
        .rd_data_o    (rdat),
        .rd_addr_o    (raddr),
        .rd_wr_ena_o  (wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_ctrl_e o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        valid = 1'b1; op = o; rs1 = a; rs2 = b; rd = d; fa = 2'b00; fb = 2'b00;
    endtask

    task automatic idle();
        valid = 1'b0; op = ALU_ADD; rs1 = '0; rs2 = '0; rd = '0; fa = 2'b00; fb = 2'b00;
    endtask

    task automatic run_alu(input string tag, input alu_ctrl_e o, input logic [1:0] sa,
                           input logic [1:0] sb, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] d, input logic [31:0] exp);
        drive(o, a, b, d);
        fa = sa; fb = sb;
        #1;
        chk({tag, " stall"}, stall, 32'd0);
        nxt();
        chk({tag, " valid"}, vo, 32'd1);
        chk({tag, " data"}, rdat, exp);
        chk({tag, " addr"}, raddr, d);
        chk({tag, " wr"}, wr, (d != 5'd0));
    endtask

    task automatic run_mc(input string tag, input alu_ctrl_e o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input int n,
                          input logic [31:0] exp);
        drive(o, a, b, d);
        #1;
        for (int i = 0; i < n; i++) begin
            chk({tag, " stall"}, stall, 32'd1);
            if (i > 0) chk({tag, " bubble"}, vo, 32'd0);
            nxt();
            if (i == 0) begin
                rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; rd = 5'd31;
            end
            #1;
        end
        chk({tag, " stall end"}, stall, 32'd0);
        chk({tag, " bubble end"}, vo, 32'd0);
        idle();
        nxt();
        chk({tag, " valid"}, vo, 32'd1);
        chk({tag, " data"}, rdat, exp);
        chk({tag, " addr"}, raddr, d);
        chk({tag, " wr"}, wr, (d != 5'd0));
    endtask

    initial begin
        fm = 32'd5;
        fw = 32'd8;
        #2;
        chk("rst valid", vo, 32'd0);
        chk("rst data", rdat, 32'd0);
        chk("rst addr", raddr, 32'd0);
        chk("rst wr", wr, 32'd0);
        chk("rst stall", stall, 32'd0);
        nxt();
        rstn = 1'b1;
        nxt();
        chk("idle valid", vo, 32'd0);

        // ALU and forwarding
        run_alu("add fwdM", ALU_ADD, 2'b10, 2'b00, 32'd123, 32'hFFFF_FFF7, 5'd3, 32'hFFFF_FFFC);
        run_alu("sub fwdW rd0", ALU_SUB, 2'b00, 2'b01, 32'd20, 32'd99, 5'd0, 32'd12);
        run_alu("and sel11", ALU_AND, 2'b11, 2'b11, 32'h0000_F0F0, 32'h0000_FF00, 5'd4, 32'h0000_F000);
        run_alu("sra", ALU_SRA, 2'b00, 2'b00, 32'h8000_0000, 32'd4, 5'd6, 32'hF800_0000);
        run_alu("slt", ALU_SLT, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd1);
        run_alu("sltu", ALU_SLTU, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0);
        imm = 32'hFFFF_FFFD;
        run_alu("addi", ALU_ADDI, 2'b00, 2'b00, 32'd10, 32'd0, 5'd7, 32'd7);
        imm = 32'h1234_5000;
        run_alu("lui", ALU_LUI, 2'b00, 2'b00, 32'd0, 32'd0, 5'd8, 32'h1234_5000);
        idle();
        nxt();
        chk("valid_i low bubble", vo, 32'd0);
        chk("valid_i low wr", wr, 32'd0);

        // Multiply
        run_mc("mul", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 2, 32'hFFFF_FFEB);
        run_mc("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 2, 32'hFFFF_FFFE);
        run_mc("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 2, 32'd0);
        run_mc("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 2, 32'hFFFF_FFFF);

        // Divide
        run_mc("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32, 32'hFFFF_FFFD);
        run_mc("rem", ALU_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32, 32'hFFFF_FFFF);
        run_mc("divu", ALU_DIVU, 32'd100, 32'd7, 5'd12, 32, 32'd14);
        run_mc("remu", ALU_REMU, 32'd100, 32'd7, 5'd13, 32, 32'd2);
        run_mc("div negdvs", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 5'd14, 32, 32'hFFFF_FFFD);
        run_mc("rem negdvs", ALU_REM, 32'd7, 32'hFFFF_FFFE, 5'd15, 32, 32'd1);

        // Divide special cases complete without stalling
        run_alu("divu by0", ALU_DIVU, 2'b00, 2'b00, 32'd10, 32'd0, 5'd16, 32'hFFFF_FFFF);
        run_alu("remu by0", ALU_REMU, 2'b00, 2'b00, 32'd10, 32'd0, 5'd16, 32'd10);
        run_alu("div by0", ALU_DIV, 2'b00, 2'b00, 32'hFFFF_FFFB, 32'd0, 5'd16, 32'hFFFF_FFFF);
        run_alu("rem ovf", ALU_REM, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0);
        run_alu("div ovf", ALU_DIV, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);

        // Flush in the tenth stall cycle of a divide
        drive(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd18);
        #1;
        for (int i = 1; i <= 9; i++) begin
            chk("flush pre stall", stall, 32'd1);
            nxt();
        end
        chk("flush cyc10 stall", stall, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush stall low", stall, 32'd0);
        chk("flush valid", vo, 32'd0);
        nxt();
        flush = 1'b0;
        drive(ALU_ADD, 32'd2, 32'd3, 5'd7);
        #1;
        chk("post flush bubble", vo, 32'd0);
        chk("post flush stall", stall, 32'd0);
        nxt();
        chk("post flush add valid", vo, 32'd1);
        chk("post flush add data", rdat, 32'd5);
        chk("post flush add addr", raddr, 32'd7);
        idle();
        for (int i = 0; i < 36; i++) begin
            nxt();
            chk("no stale div", vo, 32'd0);
        end

        // Asynchronous reset in the issue cycle of a multiply
        drive(ALU_ADD, 32'd1, 32'd2, 5'd8);
        nxt();
        drive(ALU_MUL, 32'd6, 32'd7, 5'd9);
        #1;
        chk("pre rst valid", vo, 32'd1);
        chk("pre rst data", rdat, 32'd3);
        chk("pre rst stall", stall, 32'd1);
        rstn = 1'b0;
        #1;
        chk("async rst valid", vo, 32'd0);
        chk("async rst data", rdat, 32'd0);
        chk("async rst addr", raddr, 32'd0);
        chk("async rst wr", wr, 32'd0);
        chk("async rst stall", stall, 32'd0);
        nxt();
        nxt();
        chk("held rst valid", vo, 32'd0);
        idle();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nxt();
            chk("post rst valid", vo, 32'd0);
            chk("post rst wr", wr, 32'd0);
        end
        run_alu("post rst add", ALU_ADD, 2'b00, 2'b00, 32'd40, 32'd2, 5'd1, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
